// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch front end: buffer entry layout and fetch FSM states.
// With FETCH_ADDR_CHECK_EN defined the FSM gains the HALT state entered after a misaligned redirect.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc_adel;
    } fetch_entry_t;

`ifdef FETCH_ADDR_CHECK_EN
    typedef enum logic [1:0] {REQ, WAIT, DROP, HALT} fetch_state_t;
`else
    typedef enum logic [1:0] {REQ, WAIT, DROP} fetch_state_t;
`endif

    function automatic fetch_entry_t make_entry(input logic [31:0] pc, input logic [31:0] inst,
                                                input logic exc_adel);
        fetch_entry_t e;
        e.pc       = pc;
        e.inst     = inst;
        e.exc_adel = exc_adel;
        return e;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, back-end redirect and issue-queue push.
// master = fetch unit side, slave = memory / back-end / issue-queue side.
interface fetch_unit_if #(
    parameter int IQ_ADDR_W = 3
);
    import fetch_unit_pkg::*;

    logic                 imem_req_valid;
    logic                 imem_req_ready;
    logic [31:0]          imem_req_addr;
    logic                 imem_resp_valid;
    logic [63:0]          imem_resp_data;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic [IQ_ADDR_W-1:0] iq_size_left;
    fetch_entry_t [1:0]   iq_push_data;
    logic [1:0]           iq_push_number;

    modport master (
        output imem_req_valid, imem_req_addr, iq_push_data, iq_push_number,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               iq_size_left
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, iq_push_data, iq_push_number,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               iq_size_left
    );

endinterface

// File: rtl/fetch_unit_buffer.sv
// Fetch buffer: FB_DEPTH-entry circular FIFO accepting 0-2 pushes and 0-2 pops per cycle.
// Flush empties it; a push in the flush cycle lands in the freshly emptied buffer.
module fetch_unit_buffer
    import fetch_unit_pkg::*;
#(
    parameter int  FB_DEPTH = 4,
    localparam int PTR_W    = $clog2(FB_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [1:0]         push_num,
    input  fetch_entry_t [1:0] push_data,
    input  logic [1:0]         pop_num,
    output fetch_entry_t [1:0] head_data,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     mem_q [FB_DEPTH];
    fetch_entry_t     mem_d [FB_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q + PTR_W'(pop_num);
        tail_d  = tail_q;
        count_d = count_q - CNT_W'(pop_num);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
        for (int i = 0; i < 2; i++) begin
            if (i < int'(push_num)) begin
                mem_d[tail_d + PTR_W'(i)] = push_data[i];
            end
        end
        tail_d  = tail_d + PTR_W'(push_num);
        count_d = count_d + CNT_W'(push_num);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; readers gate it with the count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data[0] = mem_q[head_q];
    assign head_data[1] = mem_q[head_q + PTR_W'(1)];
    assign count        = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC/FSM front end issuing 64-bit instruction fetches and feeding the issue queue.
// Optional FETCH_ADDR_CHECK_EN turns misaligned redirects into an exc_adel entry plus HALT.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          FB_DEPTH  = 4,
    parameter int          IQ_ADDR_W = 3
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(FB_DEPTH) + 1;

    fetch_state_t         state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic                 req_off_q, req_off_d;
    logic [CNT_W-1:0]     fb_count;
    logic [1:0]           fb_push_num;
    logic [1:0]           pop_num;
    fetch_entry_t [1:0]   fb_push_data;
    fetch_entry_t [1:0]   fb_head;
    logic                 fb_flush;
    logic                 handshake;
    logic                 resp;
    logic [31:0]          req_line;
    logic [31:0]          redir_pc;
    logic [IQ_ADDR_W-1:0] size_left;
    int                   avail;

`ifdef FETCH_ADDR_CHECK_EN
    assign redir_pc = bus.redirect_pc;
`else
    assign redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

    assign size_left = bus.iq_size_left;
    assign resp      = bus.imem_resp_valid;
    // pc has already advanced past the outstanding line while in WAIT
    assign req_line  = {pc_q[31:3] - 29'd1, 3'b000};

    assign bus.imem_req_addr  = {pc_q[31:3], 3'b000};
    assign bus.imem_req_valid = rst_n && (state_q == REQ) && (fb_count <= CNT_W'(FB_DEPTH - 2));
    assign handshake          = bus.imem_req_valid && bus.imem_req_ready;

    always_comb begin
        avail = 2;
        if (int'(fb_count) < avail) avail = int'(fb_count);
        if (int'(size_left) < avail) avail = int'(size_left);
        pop_num = bus.redirect_valid ? 2'd0 : 2'(avail);
    end

    always_comb begin
        bus.iq_push_data = '0;
        for (int i = 0; i < 2; i++) begin
            if (i < int'(pop_num)) bus.iq_push_data[i] = fb_head[i];
        end
    end

    assign bus.iq_push_number = pop_num;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_off_d    = req_off_q;
        fb_flush     = 1'b0;
        fb_push_num  = 2'd0;
        fb_push_data = '0;
        case (state_q)
            REQ: begin
                if (handshake) begin
                    req_off_d = pc_q[2];
                    pc_d      = {pc_q[31:3] + 29'd1, 3'b000};
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (resp) begin
                    state_d = REQ;
                    if (req_off_q) begin
                        fb_push_num     = 2'd1;
                        fb_push_data[0] = make_entry(req_line + 32'd4, bus.imem_resp_data[63:32], 1'b0);
                    end else begin
                        fb_push_num     = 2'd2;
                        fb_push_data[0] = make_entry(req_line, bus.imem_resp_data[31:0], 1'b0);
                        fb_push_data[1] = make_entry(req_line + 32'd4, bus.imem_resp_data[63:32], 1'b0);
                    end
                end
            end
            DROP: begin
                if (resp) state_d = REQ;
            end
            default: ;
        endcase

        if (bus.redirect_valid) begin
            pc_d         = redir_pc;
            fb_flush     = 1'b1;
            fb_push_num  = 2'd0;
            fb_push_data = '0;
            // A response arriving with the redirect settles the owed one, so no DROP is needed.
            if (state_q == WAIT || state_q == DROP) state_d = resp ? REQ : DROP;
            else if (state_q == REQ && handshake)   state_d = DROP;
            else                                    state_d = REQ;
`ifdef FETCH_ADDR_CHECK_EN
            if (redir_pc[1:0] != 2'b00) begin
                state_d         = HALT;
                fb_push_num     = 2'd1;
                fb_push_data[0] = make_entry(redir_pc, 32'd0, 1'b1);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC;
            req_off_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_off_q <= req_off_d;
        end
    end

    fetch_unit_buffer #(
        .FB_DEPTH (FB_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fb_flush),
        .push_num  (fb_push_num),
        .push_data (fb_push_data),
        .pop_num   (pop_num),
        .head_data (fb_head),
        .count     (fb_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected requests/entries, a monitor checks them.
// Covers reset, aligned/unaligned fetch, backpressure, redirects and (optionally) FETCH_ADDR_CHECK_EN.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if #(.IQ_ADDR_W(3)) bus ();

    fetch_unit #(
        .RESET_PC  (32'hBFC0_0000),
        .FB_DEPTH  (4),
        .IQ_ADDR_W (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    fetch_entry_t exp_q[$];
    logic [31:0]  exp_addr_q[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
        exp_q.push_back(make_entry(pc, inst, adel));
    endtask

    // Called just after a rising edge; returns just after the edge that completed the handshake.
    task automatic wait_hs(input logic [31:0] addr);
        bit seen = 1'b0;
        exp_addr_q.push_back(addr);
        bus.imem_req_ready = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.imem_req_valid) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_timeout: no request seen, expected addr 0x%0h", addr);
            void'(exp_addr_q.pop_back());
        end
        @(posedge clk);
        #1;
        bus.imem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [63:0] data);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = data;
        tick();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries never pushed, expected 0 left", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: request handshakes and issue-queue pushes against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    if (exp_addr_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL req_addr: unexpected request to 0x%0h, expected none", bus.imem_req_addr);
                    end else begin
                        check("req_addr", 96'(bus.imem_req_addr), 96'(exp_addr_q.pop_front()));
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if (i < int'(bus.iq_push_number)) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL push_entry: unexpected entry 0x%0h, expected none", bus.iq_push_data[i]);
                        end else begin
                            check("push_entry", 96'(bus.iq_push_data[i]), 96'(exp_q.pop_front()));
                        end
                    end else begin
                        check("push_zero", 96'(bus.iq_push_data[i]), 96'(0));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last_pc;
        rst_n               = 1'b1;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.iq_size_left    = 3'd4;
        #2 rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_valid", 96'(bus.imem_req_valid), 96'(0));
        check("rst_push_num", 96'(bus.iq_push_number), 96'(0));
        check("rst_push_data", 96'(bus.iq_push_data), 96'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: first aligned fetch from the reset PC
        wait_hs(32'hBFC0_0000);
        expect_entry(32'hBFC0_0000, 32'h2401_0001, 1'b0);
        expect_entry(32'hBFC0_0004, 32'h2402_0002, 1'b0);
        respond(64'h2402_0002_2401_0001);
        @(negedge clk);
        check("t1_push_num", 96'(bus.iq_push_number), 96'(2));
        @(posedge clk);
        #1;
        wait_hs(32'hBFC0_0008);
        expect_entry(32'hBFC0_0008, 32'h2403_0003, 1'b0);
        expect_entry(32'hBFC0_000C, 32'h2404_0004, 1'b0);
        respond(64'h2404_0004_2403_0003);
        drain();

        // 2: redirect to an odd-word PC fetches only the upper instruction
        redirect(32'h0040_0004);
        wait_hs(32'h0040_0000);
        expect_entry(32'h0040_0004, 32'hAAAA_0001, 1'b0);
        respond(64'hAAAA_0001_5555_0000);
        @(negedge clk);
        check("t2_push_num", 96'(bus.iq_push_number), 96'(1));
        @(posedge clk);
        #1;
        drain();

        // 3: issue queue full, fetch buffer fills, then drains one per cycle
        bus.iq_size_left = 3'd0;
        wait_hs(32'h0040_0008);
        respond(64'h3333_000C_3333_0008);
        wait_hs(32'h0040_0010);
        respond(64'h3333_0014_3333_0010);
        repeat (6) tick();
        @(negedge clk);
        check("t3_full_req_valid", 96'(bus.imem_req_valid), 96'(0));
        check("t3_full_push_num", 96'(bus.iq_push_number), 96'(0));
        expect_entry(32'h0040_0008, 32'h3333_0008, 1'b0);
        expect_entry(32'h0040_000C, 32'h3333_000C, 1'b0);
        expect_entry(32'h0040_0010, 32'h3333_0010, 1'b0);
        expect_entry(32'h0040_0014, 32'h3333_0014, 1'b0);
        @(posedge clk);
        #1 bus.iq_size_left = 3'd1;
        @(negedge clk);
        check("t3_push_num_a", 96'(bus.iq_push_number), 96'(1));
        @(negedge clk);
        check("t3_push_num_b", 96'(bus.iq_push_number), 96'(1));
        @(posedge clk);
        #1;
        drain();
        bus.iq_size_left = 3'd4;

        // 4: redirect while waiting; the late response is dropped
        wait_hs(32'h0040_0018);
        tick();
        redirect(32'h0040_0100);
        @(negedge clk);
        check("t4_drop_req_valid", 96'(bus.imem_req_valid), 96'(0));
        @(posedge clk);
        #1;
        tick();
        tick();
        respond(64'hDEAD_BEEF_DEAD_BEEF);
        @(negedge clk);
        check("t4_no_push", 96'(bus.iq_push_number), 96'(0));
        check("t4_req_valid", 96'(bus.imem_req_valid), 96'(1));
        check("t4_req_addr", 96'(bus.imem_req_addr), 96'(32'h0040_0100));
        @(posedge clk);
        #1;
        wait_hs(32'h0040_0100);
        expect_entry(32'h0040_0100, 32'h4444_0100, 1'b0);
        expect_entry(32'h0040_0104, 32'h4444_0104, 1'b0);
        respond(64'h4444_0104_4444_0100);
        drain();

        // 5: redirect coincident with the response
        wait_hs(32'h0040_0108);
        bus.redirect_valid  = 1'b1;
        bus.redirect_pc     = 32'h0040_0200;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 64'h5A5A_5A5A_A5A5_A5A5;
        tick();
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        @(negedge clk);
        check("t5_push_num", 96'(bus.iq_push_number), 96'(0));
        check("t5_req_valid", 96'(bus.imem_req_valid), 96'(1));
        check("t5_req_addr", 96'(bus.imem_req_addr), 96'(32'h0040_0200));
        @(posedge clk);
        #1;
        wait_hs(32'h0040_0200);
        expect_entry(32'h0040_0200, 32'h7777_0200, 1'b0);
        expect_entry(32'h0040_0204, 32'h7777_0204, 1'b0);
        respond(64'h7777_0204_7777_0200);
        drain();

        // 6: misaligned redirect
`ifdef FETCH_ADDR_CHECK_EN
        expect_entry(32'h0040_0002, 32'h0000_0000, 1'b1);
        redirect(32'h0040_0002);
        @(negedge clk);
        check("t6_push_num", 96'(bus.iq_push_number), 96'(1));
        check("t6_req_valid", 96'(bus.imem_req_valid), 96'(0));
        @(posedge clk);
        #1;
        repeat (5) tick();
        @(negedge clk);
        check("t6_halt_req_valid", 96'(bus.imem_req_valid), 96'(0));
        @(posedge clk);
        #1;
        drain();
        redirect(32'h0040_0300);
        wait_hs(32'h0040_0300);
        expect_entry(32'h0040_0300, 32'h8888_0300, 1'b0);
        expect_entry(32'h0040_0304, 32'h8888_0304, 1'b0);
        respond(64'h8888_0304_8888_0300);
        drain();
        last_pc = 32'h0040_0308;
`else
        redirect(32'h0040_0006);
        wait_hs(32'h0040_0000);
        expect_entry(32'h0040_0004, 32'h6666_0004, 1'b0);
        respond(64'h6666_0004_6666_0000);
        @(negedge clk);
        check("t6_push_num", 96'(bus.iq_push_number), 96'(1));
        @(posedge clk);
        #1;
        drain();
        last_pc = 32'h0040_0008;
`endif

        // 7: reset asserted while a fetch is outstanding
        wait_hs(last_pc);
        rst_n = 1'b0;
        #1;
        check("t7_rst_req_valid", 96'(bus.imem_req_valid), 96'(0));
        check("t7_rst_push_num", 96'(bus.iq_push_number), 96'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t7_req_valid", 96'(bus.imem_req_valid), 96'(1));
        check("t7_req_addr", 96'(bus.imem_req_addr), 96'(32'hBFC0_0000));
        @(posedge clk);
        #1;
        check("left_addr", 96'(exp_addr_q.size()), 96'(0));
        check("left_entries", 96'(exp_q.size()), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Front-end stage directly upstream of issue_queue; supplies the entries that fill the issue queue's input.
- Holds the PC and issues 64-bit (two-instruction) requests to instruction memory over a valid/ready handshake, one request outstanding at a time.
- Buffers returned instructions in a small multi-push/multi-pop FIFO.
- Pushes 0–2 instructions per cycle into the issue queue, bounded by its size_left.
- Branch redirects from the back end flush the buffer and discard any in-flight response.

Parameters:
RESET_PC, 32'hBFC0_0000, PC loaded on reset.
FB_DEPTH, 4, fetch buffer capacity in instructions (power of two, >=2).
IQ_ADDR_W, 3, width of iq_size_left (matches IQ_ADDR).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request this cycle.
imem_req_addr  out  32  8-byte-aligned address {pc[31:3],3'b000}.
imem_resp_valid  in  1  response data valid (exactly one per accepted request, >=1 cycle later).
imem_resp_data  in  64  {inst at addr+4, inst at addr+0}.
redirect_valid  in  1  back-end redirect (branch/exception).
redirect_pc  in  32  new fetch PC.
iq_size_left  in  IQ_ADDR_W  free issue-queue slots.
iq_push_data  out  2 x FETCH_ENTRY  slot 0 = older instruction.
iq_push_number  out  2  number of valid slots pushed this cycle (0..2).

Behaviour:
- Reset (async assert):
  - pc=RESET_PC; state=REQ; buffer count=0.
  - imem_req_valid=0 and iq_push_number=0 while rst_n low.
  - iq_push_data=0.
- States:
  - REQ: imem_req_valid=1 iff count+2<=FB_DEPTH. On handshake (valid&&ready): latch req_off=pc[2]; pc<=pc[31:3]*8+8; go WAIT.
  - WAIT: await imem_resp_valid; push instructions (below); go REQ.
  - DROP: await imem_resp_valid; discard data; go REQ.
  - In REQ, a response arriving with nothing outstanding is ignored.
- Response push: req_off=0 pushes two entries (pc, +4); req_off=1 pushes only the upper word with pc = line address+4.
- Pop/push to the issue queue:
  - iq_push_number = min(count, iq_size_left, 2), computed combinationally from registered count and iq_size_left.
  - iq_push_data comes from the buffer head; slots at or beyond iq_push_number are driven 0.
  - Same-cycle buffer push and pop are both honoured; count' = count + pushed − popped.
  - The REQ credit check guarantees no overflow.
- Redirect (highest priority): pc<=redirect_pc; buffer flushed (count=0) and iq_push_number forced 0 that cycle.
  - In WAIT, or in REQ with a handshake in the same cycle: go DROP.
  - In WAIT with a simultaneous resp: discard the resp, go REQ.
  - In DROP: stay DROP (the old response is still owed).
  - Otherwise: REQ.
- FIFO pointers wrap modulo FB_DEPTH. Full = count==FB_DEPTH. Empty produces no push.
- Reset asserted mid-WAIT: state returns to REQ. The memory side is reset by the same rst_n, so no stale response is expected.

Optional Feature:
Macro FETCH_ADDR_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 issues no memory request.
  - Instead, one entry {pc=redirect_pc, inst=0, exc_adel=1} is pushed into the buffer.
  - The unit then enters state HALT (imem_req_valid=0) until the next redirect.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00; exc_adel is always 0; HALT does not exist.

Decomposition:
- defines.svh package:
  - FETCH_ENTRY struct {logic[31:0] pc; logic[31:0] inst; bool exc_adel}.
  - FETCH_STATE enum {REQ, WAIT, DROP, HALT}.
  - RESET_PC default constant.
- Sub-module fetch_buffer:
  - Parameterised FIFO, FB_DEPTH entries.
  - Push 0–2 and pop 0–2 per cycle; flush input; count output.
- fetch_unit holds the PC/FSM logic and instantiates fetch_buffer.

Test Plan:
1. Reset then ready=1, resp one cycle later with data {0x24020002,0x24010001} -> first imem_req_addr=0xBFC00000; entries pc 0xBFC00000/0xBFC00004 pushed, iq_push_number=2; next request addr 0xBFC00008.
2. redirect_pc=0x00400004 -> req addr 0x00400000; resp pushes a single entry pc=0x00400004 with inst=data[63:32].
3. iq_size_left=0 for 10 cycles -> buffer fills to FB_DEPTH=4; imem_req_valid drops to 0; iq_size_left=1 -> iq_push_number=1 per cycle, in order.
4. Redirect to 0x00400100 while in WAIT, response arrives 3 cycles later -> response discarded (no push); next req addr 0x00400100.
5. Redirect coincident with resp_valid in WAIT -> no push, buffer empty, next cycle imem_req_valid=1 at the redirect address.
6. With FETCH_ADDR_CHECK_EN, redirect_pc=0x00400002 -> one entry exc_adel=1, pc=0x00400002 pushed; imem_req_valid stays 0 until the next redirect.
